// File: rtl/uart_rx_deserializer_if.sv
// UART RX interface: serial line and frame configuration in, parallel word and
// one-cycle result pulses out. The slave modport is the receiver side.
interface uart_rx_deserializer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  i_rx_in;
    logic [5:0]            i_prescale;
    logic                  i_par_en;
    logic                  i_par_typ;
    logic [DATA_WIDTH-1:0] o_p_data;
    logic                  o_data_valid;
    logic                  o_par_err;
    logic                  o_stp_err;

    modport slave (
        input  i_rx_in,
        input  i_prescale,
        input  i_par_en,
        input  i_par_typ,
        output o_p_data,
        output o_data_valid,
        output o_par_err,
        output o_stp_err
    );

    modport master (
        output i_rx_in,
        output i_prescale,
        output i_par_en,
        output i_par_typ,
        input  o_p_data,
        input  o_data_valid,
        input  o_par_err,
        input  o_stp_err
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer. Samples the serial line on an oversampling clock
// (prescale cycles per bit), assembles DATA_WIDTH bits LSB-first, optionally
// checks parity and validates the stop bit. A good frame loads o_p_data with a
// one-cycle o_data_valid pulse; a bad one gives a one-cycle error pulse instead.
//
// Optional build macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority of
// samples at edge_cnt P/2-1, P/2 and P/2+1 instead of a single sample at P/2.
module uart_rx_deserializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic                   i_clk,
    input logic                   i_rst,
    uart_rx_deserializer_if.slave rx_if
);

    localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e state_q, state_d;

    logic [5:0]            edge_cnt_q, edge_cnt_d;
    logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [5:0]            prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  sample_q, sample_d;
    logic                  par_mismatch_q, par_mismatch_d;

    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

`ifdef UART_RX_MAJORITY_EN
    logic samp_a_q, samp_a_d;
    logic samp_b_q, samp_b_d;
`endif

    logic       rx;
    logic [5:0] half_p;
    logic       bit_end;

    assign rx      = rx_if.i_rx_in;
    assign half_p  = {1'b0, prescale_q[5:1]};
    assign bit_end = (edge_cnt_q == (prescale_q - 6'd1));

    // Next-state, counters, bit sampling and frame resolution.
    always_comb begin
        state_d        = state_q;
        edge_cnt_d     = edge_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        prescale_d     = prescale_q;
        par_en_d       = par_en_q;
        par_typ_d      = par_typ_q;
        shift_d        = shift_q;
        sample_d       = sample_q;
        par_mismatch_d = par_mismatch_q;
        p_data_d       = p_data_q;
        data_valid_d   = 1'b0;
        par_err_d      = 1'b0;
        stp_err_d      = 1'b0;
`ifdef UART_RX_MAJORITY_EN
        samp_a_d       = samp_a_q;
        samp_b_d       = samp_b_q;
`endif

        // Bit-period counter runs in every state except IDLE.
        if (state_q != StIdle) begin
            edge_cnt_d = bit_end ? 6'd0 : (edge_cnt_q + 6'd1);
        end

`ifdef UART_RX_MAJORITY_EN
        // Two early samples are held; the third is the live line at P/2+1.
        if (state_q != StIdle) begin
            if (edge_cnt_q == (half_p - 6'd1)) begin
                samp_a_d = rx;
            end
            if (edge_cnt_q == half_p) begin
                samp_b_d = rx;
            end
            if (edge_cnt_q == (half_p + 6'd1)) begin
                sample_d = (samp_a_q & samp_b_q) | (samp_a_q & rx) | (samp_b_q & rx);
            end
        end
`else
        if ((state_q != StIdle) && (edge_cnt_q == half_p)) begin
            sample_d = rx;
        end
`endif

        case (state_q)
            StIdle: begin
                if (!rx) begin
                    state_d        = StStart;
                    edge_cnt_d     = 6'd0;
                    bit_cnt_d      = '0;
                    par_mismatch_d = 1'b0;
                    // Frame configuration is frozen for the whole frame.
                    prescale_d     = rx_if.i_prescale;
                    par_en_d       = rx_if.i_par_en;
                    par_typ_d      = rx_if.i_par_typ;
                end
            end

            StStart: begin
                if (bit_end) begin
                    // A high mid-bit sample means the low level was a glitch.
                    state_d = sample_q ? StIdle : StData;
                end
            end

            StData: begin
                if (bit_end) begin
                    // Shift right so the first received bit ends up in bit 0.
                    shift_d                 = shift_q >> 1;
                    shift_d[DATA_WIDTH-1]   = sample_q;
                    if (bit_cnt_q == LastBit) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            StParity: begin
                if (bit_end) begin
                    par_mismatch_d = sample_q ^ (^shift_q) ^ par_typ_q;
                    state_d        = StStop;
                end
            end

            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    // A framing error takes precedence over a parity error.
                    if (!sample_q) begin
                        stp_err_d = 1'b1;
                    end else if (par_mismatch_q) begin
                        par_err_d = 1'b1;
                    end else begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, latched configuration and the receive datapath.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            edge_cnt_q     <= 6'd0;
            bit_cnt_q      <= '0;
            prescale_q     <= 6'd8;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            shift_q        <= '0;
            sample_q       <= 1'b1;
            par_mismatch_q <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            samp_a_q       <= 1'b1;
            samp_b_q       <= 1'b1;
`endif
        end else begin
            edge_cnt_q     <= edge_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            prescale_q     <= prescale_d;
            par_en_q       <= par_en_d;
            par_typ_q      <= par_typ_d;
            shift_q        <= shift_d;
            sample_q       <= sample_d;
            par_mismatch_q <= par_mismatch_d;
`ifdef UART_RX_MAJORITY_EN
            samp_a_q       <= samp_a_d;
            samp_b_q       <= samp_b_d;
`endif
        end
    end

    // Registered outputs: held word and one-cycle result pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign rx_if.o_p_data     = p_data_q;
    assign rx_if.o_data_valid = data_valid_q;
    assign rx_if.o_par_err    = par_err_q;
    assign rx_if.o_stp_err    = stp_err_q;

endmodule
